// File: rtl/mul_iter_param_if.sv
// Handshake and operand bus of the iterative multiplier.
// The master issues start/operands and the slave returns busy/done/result.
interface mul_iter_param_if #(
    parameter int W = 64
);
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   mul1;
    logic [W-1:0]   mul2;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    modport master (
        output start, signed_mode, mul1, mul2,
        input  busy, done, result
    );

    modport slave (
        input  start, signed_mode, mul1, mul2,
        output busy, done, result
    );
endinterface

// File: rtl/mul_iter_param.sv
// Iterative WxW multiplier that uses P parallel DxD digit multipliers per cycle.
// Signed operands are reduced to magnitudes, and the final product is negated in the FIN cycle.
module mul_iter_param #(
    parameter int W = 64,
    parameter int D = 16,
    parameter int P = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_iter_param_if.slave bus
);
    localparam int N  = W / D;
    localparam int C  = N / P;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int AW = 2 * W;

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_reg, b_reg;
    logic            neg;
    logic [AW-1:0]   acc, acc_add;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic            busy_q, done_q;
    logic [AW-1:0]   result_q;
    logic [W-1:0]    a_mag, b_mag;
    logic            last_step;
    logic [D-1:0]    a_dig, b_dig;
    logic [2*D-1:0]  prod;

    assign a_mag = (bus.signed_mode && bus.mul1[W-1]) ? -bus.mul1 : bus.mul1;
    assign b_mag = (bus.signed_mode && bus.mul2[W-1]) ? -bus.mul2 : bus.mul2;
    assign last_step = (row == RW'(N - 1)) && (col == CW'(C - 1));

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // One row digit of a times P consecutive digits of b, aligned and summed in one adder tree
    always_comb begin
        acc_add = '0;
        b_dig   = '0;
        prod    = '0;
        a_dig   = a_reg[int'(row)*D +: D];
        for (int k = 0; k < P; k++) begin
            b_dig   = b_reg[(int'(col)*P + k)*D +: D];
            prod    = {{D{1'b0}}, a_dig} * {{D{1'b0}}, b_dig};
            acc_add = acc_add + (AW'(prod) << (D*(int'(row) + int'(col)*P + k)));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = MUL;
            MUL:     if (last_step) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            row      <= '0;
            col      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= a_mag;
                        b_reg  <= b_mag;
                        neg    <= bus.signed_mode & (bus.mul1[W-1] ^ bus.mul2[W-1]);
                        acc    <= '0;
                        row    <= '0;
                        col    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                MUL: begin
                    acc <= acc + acc_add;
                    if (last_step) begin
                        row <= '0;
                        col <= '0;
                    end else if (col == CW'(C - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                FIN: begin
                    result_q <= neg ? -acc : acc;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
